apb_slave_mem: RTL
==================

// Module: apb_slave_mem
// PURPOSE
//  APB3 completer sitting directly downstream of master_apb: consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA,
//  returns PREADY/PRDATA/PSLVERR. Backs a word-addressed DEPTH x DATA_WIDTH storage array with a
//  fixed, parameterised number of wait states per access. Serves as bus target in system sims and benches.
// PARAMETERS
//  ADDR_WIDTH   8    PADDR width; PADDR is a word index (no byte lanes)
//  DATA_WIDTH   32   PWDATA/PRDATA width
//  DEPTH        64   number of storage words; legal addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_WIDTH)
//  WAIT_CYCLES  1    wait states inserted per access phase (0..15)
// PORTS
//  PCLK     in   1           bus clock, all state on rising edge
//  PRESET   in   1           asynchronous, active-high reset
//  PSEL     in   1           select from master
//  PENABLE  in   1           access-phase strobe
//  PWRITE   in   1           1=write, 0=read
//  PADDR    in   ADDR_WIDTH  word address
//  PWDATA   in   DATA_WIDTH  write data
//  PREADY   out  1           transfer-complete strobe (registered)
//  PRDATA   out  DATA_WIDTH  read data, valid when PREADY=1 and PWRITE=0 (registered)
//  PSLVERR  out  1           error, valid only with PREADY=1 (registered)
// BEHAVIOUR
//  - Reset (PRESET=1, any time, async): state=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, wait counter=0.
//    Storage array is NOT reset; contents undefined until written. In-flight transfer is dropped, no write.
//  - FSM: IDLE -> SETUP -> ACCESS -> (IDLE | SETUP).
//    IDLE:   PSEL=1 & PENABLE=0 sampled -> SETUP; latch PADDR/PWRITE/PWDATA; cnt<=WAIT_CYCLES.
//            PENABLE=1 without prior setup is a protocol error: ignored, stay IDLE, PREADY stays 0.
//    SETUP:  next edge -> ACCESS. If cnt==0, PREADY<=1 on this edge (zero-wait: PREADY high in 1st access cycle).
//    ACCESS: while PREADY=0 and PSEL&PENABLE: cnt decrements; when cnt reaches 0, PREADY<=1 next edge.
//            Access phase therefore lasts exactly WAIT_CYCLES+1 cycles.
//            Edge where PREADY=1 is sampled by master = completion: write committed to array on the
//            edge that raises PREADY (data from latched PWDATA); PRDATA loaded same edge.
//            After completion PREADY<=0 next edge; if PSEL=1&PENABLE=0 then -> SETUP (back-to-back), else IDLE.
//    Abort: PSEL=0 while in SETUP/ACCESS before PREADY -> IDLE, no write, PREADY stays 0.
//  - Address check: latched PADDR >= DEPTH -> PSLVERR=1 with PREADY, write suppressed, PRDATA=0.
//    PSLVERR=0 whenever PREADY=0.
//  - Reads of written locations return last written value; write then read of same address in
//    consecutive transfers returns new data (no forwarding hazard: write commits before next setup).
//  - PRDATA holds its last value between transfers; during writes PRDATA is not updated.
//  - Only PADDR[clog2(DEPTH)-1:0] indexes the array; upper bits used solely for the range check.
// STRUCTURE
//  - Shared include apb_defs.vh: FSM state localparams (ST_IDLE, ST_SETUP, ST_ACCESS), default
//    ADDR_WIDTH/DATA_WIDTH, used by master_apb and this block alike.
//  - One sub-module: apb_slave_regfile (sync write port with enable, async-index read port, DEPTH x DATA_WIDTH).
//  - Top holds FSM, wait counter, address latch, range check and output registers.
// TESTING
//  1 Reset: PRESET=1 for 3 cycles -> PREADY=0, PRDATA=0, PSLVERR=0; release, idle bus -> outputs unchanged.
//  2 Write/read, WAIT_CYCLES=1: write PADDR=3 PWDATA=9 -> PREADY high in 2nd access cycle, PSLVERR=0;
//    read PADDR=3 -> PRDATA=9 with PREADY; read PADDR=7 after write 13 to 7 -> PRDATA=13.
//  3 Wait states: WAIT_CYCLES=0 -> PREADY in 1st access cycle; WAIT_CYCLES=3 -> PREADY in 4th; PREADY
//    pulse exactly 1 cycle each time.
//  4 Error: write PADDR=64 (DEPTH=64) data 0xA5 -> PREADY=1 & PSLVERR=1; read 64 -> PRDATA=0, PSLVERR=1;
//    read 0 afterwards unaffected.
//  5 Abort/reset mid-transfer: write PADDR=5 data 0x55, drop PSEL during wait -> no PREADY, read 5 returns
//    prior value; assert PRESET during access -> PREADY=0 immediately (async), no write committed.
//  6 Back-to-back: write 1<=0x11 then immediately setup read 1 (no idle cycle) -> PRDATA=0x11;
//    PENABLE=1 with no setup from IDLE -> no PREADY.

Source files
------------

// File: rtl/apb_slave_mem_pkg.sv
// Shared definitions for the APB3 memory completer: FSM states and bus defaults.
package apb_slave_mem_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;
  localparam int CNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  function automatic logic [CNT_WIDTH-1:0] wait_load(input int wait_cycles);
    return CNT_WIDTH'(wait_cycles);
  endfunction

endpackage

// File: rtl/apb_slave_mem_regfile.sv
// Storage array for the APB completer: synchronous write port, combinational-index read port.
module apb_slave_mem_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed memory with a fixed number of wait states per access.
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;

  logic                  done;
  logic                  in_range;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Upper address bits only feed the range check; the array sees the low index bits.
  assign in_range = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(DEPTH));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_SETUP;
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = wait_load(WAIT_CYCLES);
        end
      end
      ST_SETUP: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
          done    = (cnt_q == '0);
        end
      end
      ST_ACCESS: begin
        if (pready_q) begin
          if (PSEL && !PENABLE) begin
            state_d = ST_SETUP;
            addr_d  = PADDR;
            write_d = PWRITE;
            wdata_d = PWDATA;
            cnt_d   = wait_load(WAIT_CYCLES);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          // The edge on which the count runs out is the completion edge.
          if (cnt_q <= CNT_WIDTH'(1)) begin
            cnt_d = '0;
            done  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pready_d  = done;
    pslverr_d = done && !in_range;
    mem_we    = done && write_q && in_range;
    prdata_d  = prdata_q;
    if (done && !write_q) begin
      prdata_d = in_range ? mem_rdata : '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  apb_slave_mem_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_regfile (
    .clk  (PCLK),
    .we   (mem_we),
    .waddr(addr_q[IDX_WIDTH-1:0]),
    .wdata(wdata_q),
    .raddr(addr_q[IDX_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

  assign PREADY  = pready_q;
  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;

endmodule
